ceu_fpmul_arbiter: RTL and testbench

- Shares one pipelined fp_multiplier among NUM_REQ CEU channel requesters (e.g. the x/y/z covariance-update channels).
- Uses round-robin arbitration and issues at most one multiply per cycle.
- Tracks in-flight operations in order with a tag FIFO and routes each mul_finish result back to the requester that issued it.
- Sits between the CEU channel datapaths and a single shared fp_multiplier instance.

---
 rtl/ceu_fpmul_arbiter_if.sv | 28 ++
 rtl/ceu_fpmul_arbiter.sv | 159 +++++++++++++++
 tb/tb_ceu_fpmul_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ceu_fpmul_arbiter_if.sv
// Requester and multiplier-side signals of the shared fp_multiplier arbiter.
// The arbiter uses the slave modport; channel datapaths and the multiplier use master.
interface ceu_fpmul_arbiter_if #(
  parameter int unsigned DBL_WIDTH = 64,
  parameter int unsigned NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DBL_WIDTH-1:0] req_a;
  logic [NUM_REQ*DBL_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DBL_WIDTH-1:0]         rsp_result;
  logic                         mul_valid;
  logic [DBL_WIDTH-1:0]         mul_a;
  logic [DBL_WIDTH-1:0]         mul_b;
  logic                         mul_finish;
  logic [DBL_WIDTH-1:0]         mul_result;

  modport master (
    output req, req_a, req_b, mul_finish, mul_result,
    input  gnt, rsp_valid, rsp_result, mul_valid, mul_a, mul_b
  );

  modport slave (
    input  req, req_a, req_b, mul_finish, mul_result,
    output gnt, rsp_valid, rsp_result, mul_valid, mul_a, mul_b
  );
endinterface

// File: rtl/ceu_fpmul_arbiter.sv
// Round-robin arbiter sharing one pipelined fp_multiplier among NUM_REQ CEU channels.
// Optional perf counters are built when CEU_ARB_PERF_EN is defined.
module ceu_fpmul_arbiter #(
  parameter int unsigned DBL_WIDTH = 64,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  ceu_fpmul_arbiter_if.slave bus,
  output logic               busy,
  output logic               err_underflow,
  output logic [31:0]        perf_issue_cnt,
  output logic [31:0]        perf_stall_cnt
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef logic [NUM_REQ-1:0]   req_t;
  typedef logic [IdxW-1:0]      idx_t;
  typedef logic [PtrW-1:0]      ptr_t;
  typedef logic [PtrW:0]        cnt_t;
  typedef logic [DBL_WIDTH-1:0] dbl_t;

  req_t gnt_q, gnt_d, rsp_valid_q, rsp_valid_d, eligible;
  idx_t rr_ptr_q, rr_ptr_d, win_idx, cand;
  logic mul_valid_q, mul_valid_d, err_q, err_d;
  logic win_found, full, launch, pop;
  dbl_t mul_a_q, mul_a_d, mul_b_q, mul_b_d, rsp_result_q, rsp_result_d;
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t cnt_q, cnt_d;
  idx_t tag_mem [TAG_DEPTH];
  dbl_t op_a [NUM_REQ];
  dbl_t op_b [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = bus.req_a[i*DBL_WIDTH +: DBL_WIDTH];
      op_b[i] = bus.req_b[i*DBL_WIDTH +: DBL_WIDTH];
    end
  end

  // Last cycle's grant is masked so a requester still holding its operands is not re-issued.
  always_comb begin
    eligible  = bus.req & ~gnt_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = idx_t'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    full   = (cnt_q == cnt_t'(TAG_DEPTH));
    launch = win_found & ~full;
    pop    = bus.mul_finish & (cnt_q != '0);

    gnt_d       = launch ? (req_t'(1) << win_idx) : '0;
    mul_valid_d = launch;
    mul_a_d     = launch ? op_a[win_idx] : mul_a_q;
    mul_b_d     = launch ? op_b[win_idx] : mul_b_q;
    rr_ptr_d    = rr_ptr_q;
    if (launch) begin
      rr_ptr_d = (win_idx == idx_t'(NUM_REQ - 1)) ? '0 : win_idx + idx_t'(1);
    end

    wr_ptr_d = launch ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    case ({launch, pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase

    rsp_valid_d  = pop ? (req_t'(1) << tag_mem[rd_ptr_q]) : '0;
    rsp_result_d = pop ? bus.mul_result : rsp_result_q;
    err_d        = err_q | (bus.mul_finish & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rr_ptr_q     <= '0;
      mul_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_result_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      mul_valid_q  <= mul_valid_d;
      err_q        <= err_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_result_q <= rsp_result_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Tag storage needs no reset: entries are only read while cnt_q says they are valid.
  always_ff @(posedge clk) begin
    if (launch) begin
      tag_mem[wr_ptr_q] <= win_idx;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.mul_valid  = mul_valid_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign busy           = (cnt_q != '0) | mul_valid_q;
  assign err_underflow  = err_q;

`ifdef CEU_ARB_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (launch && (issue_cnt_q != '1)) begin
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
    if ((|eligible) && full && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ceu_fpmul_arbiter.sv
// Self-checking bench for ceu_fpmul_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model and a latency-3 multiplier.
module tb_ceu_fpmul_arbiter;
  localparam int unsigned DW  = 64;
  localparam int unsigned NR  = 4;
  localparam int unsigned TD  = 8;
  localparam int          LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic        err_underflow;
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;

  ceu_fpmul_arbiter_if #(.DBL_WIDTH(DW), .NUM_REQ(NR)) bus ();

  ceu_fpmul_arbiter #(
    .DBL_WIDTH(DW),
    .NUM_REQ  (NR),
    .TAG_DEPTH(TD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy          (busy),
    .err_underflow (err_underflow),
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] res;
    int          due;
  } pend_t;

  // Multiplier stub state and requester state
  pend_t       pend[$];
  bit          stall = 1'b0;
  bit          force_fin = 1'b0;
  bit          auto_req = 1'b0;
  int          fin_credit = 0;
  bit          hold [NR];
  logic [63:0] op_a [NR];
  logic [63:0] op_b [NR];

  // Reference model state
  int            m_ptr;
  int            m_prev;
  int            m_tags[$];
  bit            m_err;
  logic [63:0]   m_a, m_b, m_res;
  logic [31:0]   m_issue, m_stall;
  logic [NR-1:0] e_gnt, e_rsp;
  bit            e_mv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mul64(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_op();
    return $realtobits(real'($urandom_range(1, 4000)) / 16.0);
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_prev  = -1;
    m_tags.delete();
    m_err   = 1'b0;
    m_a     = '0;
    m_b     = '0;
    m_res   = '0;
    m_issue = '0;
    m_stall = '0;
    e_gnt   = '0;
    e_rsp   = '0;
    e_mv    = 1'b0;
  endtask

  task automatic clear_env();
    pend.delete();
    stall      = 1'b0;
    force_fin  = 1'b0;
    fin_credit = 0;
    auto_req   = 1'b0;
    for (int i = 0; i < NR; i++) hold[i] = 1'b0;
    bus.req        = '0;
    bus.mul_finish = 1'b0;
  endtask

  // One clock: drive inputs, predict, step, compare, react.
  task automatic cycle();
    logic [NR-1:0] elig;
    int            w;
    bit            full_now;
    pend_t         p;
    bus.mul_finish = 1'b0;
    if (force_fin) begin
      bus.mul_finish = 1'b1;
      bus.mul_result = rand_op();
      force_fin      = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc + 1 && (!stall || fin_credit > 0)) begin
      bus.mul_finish = 1'b1;
      bus.mul_result = pend[0].res;
      void'(pend.pop_front());
      if (stall) fin_credit--;
    end
    for (int i = 0; i < NR; i++) begin
      bus.req[i]            = hold[i];
      bus.req_a[i*DW +: DW] = op_a[i];
      bus.req_b[i*DW +: DW] = op_b[i];
    end

    elig = '0;
    for (int i = 0; i < NR; i++) if (hold[i] && i != m_prev) elig[i] = 1'b1;
    full_now = (m_tags.size() == TD);
    w = -1;
    if (elig != '0 && !full_now) begin
      for (int k = 0; k < NR; k++) if (w < 0 && elig[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
    end
    e_rsp = '0;
    if (bus.mul_finish) begin
      if (m_tags.size() > 0) begin
        e_rsp[m_tags.pop_front()] = 1'b1;
        m_res = bus.mul_result;
      end else begin
        m_err = 1'b1;
      end
    end
    if (elig != '0 && full_now && m_stall != '1) m_stall++;
    e_gnt = '0;
    e_mv  = (w >= 0);
    if (w >= 0) begin
      m_tags.push_back(w);
      e_gnt[w] = 1'b1;
      m_a      = op_a[w];
      m_b      = op_b[w];
      m_ptr    = (w + 1) % NR;
      m_prev   = w;
      if (m_issue != '1) m_issue++;
    end else begin
      m_prev = -1;
    end

    @(posedge clk);
    #1;
    check("gnt", 64'(bus.gnt), 64'(e_gnt));
    check("mul_valid", 64'(bus.mul_valid), 64'(e_mv));
    check("mul_a", bus.mul_a, m_a);
    check("mul_b", bus.mul_b, m_b);
    check("rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp));
    check("rsp_result", bus.rsp_result, m_res);
    check("busy", 64'(busy), 64'((m_tags.size() != 0) || e_mv));
    check("err_underflow", 64'(err_underflow), 64'(m_err));
`ifdef CEU_ARB_PERF_EN
    check("perf_issue", 64'(perf_issue_cnt), 64'(m_issue));
    check("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
`else
    check("perf_issue", 64'(perf_issue_cnt), 64'd0);
    check("perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif

    if (e_mv) begin
      p.res = mul64(m_a, m_b);
      p.due = cyc + LAT;
      pend.push_back(p);
    end
    if (auto_req) begin
      for (int i = 0; i < NR; i++) begin
        if (e_gnt[i]) hold[i] = 1'b0;
        if (!hold[i] && $urandom_range(0, 99) < 40) begin
          hold[i] = 1'b1;
          op_a[i] = rand_op();
          op_b[i] = rand_op();
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    auto_req = 1'b0;
    stall    = 1'b0;
    for (int i = 0; i < NR; i++) hold[i] = 1'b0;
    while ((m_tags.size() != 0 || pend.size() != 0 || e_mv) && n < 40) begin
      cycle();
      n++;
    end
    if (n >= 40) check("drain_timeout", 64'(m_tags.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_mul_valid", 64'(bus.mul_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_underflow), 64'd0);
    model_reset();
    clear_env();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int gnt_seen;
    int launches;
    int n;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    clear_env();
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.mul_result = '0;
    rst_n          = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    pulse_reset();

    // Lone requester: grants every other cycle, each result is 6.0
    op_a[0] = 64'h4000000000000000;
    op_b[0] = 64'h4008000000000000;
    hold[0] = 1'b1;
    gnt_seen = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (bus.gnt[0]) gnt_seen++;
    end
    hold[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (bus.rsp_valid[0]) check("t1_result", bus.rsp_result, 64'h4018000000000000);
    end
    check("t1_grants", 64'(gnt_seen), 64'd3);

    // All requesters held: back-to-back round-robin launches
    for (int i = 0; i < NR; i++) begin
      hold[i] = 1'b1;
      op_a[i] = rand_op();
      op_b[i] = rand_op();
    end
    for (int c = 0; c < 12; c++) cycle();
    drain();

    // Stalled multiplier fills the tag FIFO, then one finish resumes grants
    stall = 1'b1;
    for (int i = 0; i < NR; i++) hold[i] = 1'b1;
    launches = 0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (bus.mul_valid) launches++;
    end
    check("t3_launches", 64'(launches), 64'(TD));
    check("t3_busy", 64'(busy), 64'd1);
    fin_credit = 1;
    cycle();
    cycle();
    check("t3_resume", 64'(|bus.gnt), 64'd1);
    drain();

    // Launch and finish on the same edge with five ops in flight
    stall   = 1'b1;
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    n = 0;
    while (m_tags.size() < 5 && n < 20) begin
      cycle();
      n++;
    end
    fin_credit = 1;
    cycle();
    cycle();
    drain();

    // Spurious finish with nothing in flight
    force_fin = 1'b1;
    cycle();
    check("t5_no_rsp", 64'(bus.rsp_valid), 64'd0);
    check("t5_err", 64'(err_underflow), 64'd1);

    // Random traffic with random multiplier back-pressure; error stays sticky
    auto_req = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 9) == 0) stall = !stall;
      if (stall && $urandom_range(0, 2) == 0) fin_credit = 1;
      cycle();
    end
    check("t5_err_sticky", 64'(err_underflow), 64'd1);
    drain();

    // Reset with three ops in flight, then lowest-index requester wins first
    stall   = 1'b1;
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    n = 0;
    while (m_tags.size() < 3 && n < 20) begin
      cycle();
      n++;
    end
    pulse_reset();
    hold[2] = 1'b1;
    hold[3] = 1'b1;
    cycle();
    check("t6_first_gnt", 64'(bus.gnt), 64'h4);

    auto_req = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if ($urandom_range(0, 9) == 0) stall = !stall;
      if (stall && $urandom_range(0, 2) == 0) fin_credit = 1;
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
